// File: rtl/mem_port_requester_if.sv
// mem_port_requester_if: request/response channels and RAM-port signals of one requester
interface mem_port_requester_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [ADDR_W-1:0]     rsp_addr;
    logic                  wr_done;
    logic                  en;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    modport master (
        input  req_valid, req_we, req_addr, req_data, rsp_ready, dout,
        output req_ready, rsp_valid, rsp_data, rsp_addr, wr_done, en, we, addr, din
    );
    modport slave (
        output req_valid, req_we, req_addr, req_data, rsp_ready, dout,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, wr_done, en, we, addr, din
    );
endinterface

// File: rtl/mem_port_requester.sv
// mem_port_requester: valid/ready front end for one RAM port, capturing reads at their latency into a FWFT response FIFO
module mem_port_requester #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_DEPTH = 16,
    parameter int R_LATENCY     = 2,
    parameter int W_LATENCY     = 1,
    parameter int RSP_DEPTH     = 4
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    mem_port_requester_if.master bus
);
    localparam int ADDR_W = $clog2(ADDRESS_DEPTH);
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int SUM_W  = CNT_W + 1;
    localparam int PTR_W  = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;

    logic                  en_q, en_d, we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [R_LATENCY-1:0]  rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0]     rd_addr_q [R_LATENCY];
    logic [ADDR_W-1:0]     rd_addr_d [R_LATENCY];
    logic [W_LATENCY-1:0]  wr_pipe_q, wr_pipe_d;
    logic [CNT_W-1:0]      rd_out_q, rd_out_d, fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [RSP_DEPTH];
    logic [ADDR_W-1:0]     fifo_addr_q [RSP_DEPTH];
    logic [ADDR_W-1:0]     fifo_addr_d [RSP_DEPTH];
    logic                  req_ready, rd_acc, wr_acc, push, pop;

    always_comb begin
        // a read waits out any write still in its pipe so it observes the written data
        req_ready = i_rst_n && ({1'b0, rd_out_q} + {1'b0, fifo_cnt_q} < SUM_W'(RSP_DEPTH))
                    && !(!bus.req_we && |wr_pipe_q);
        rd_acc = bus.req_valid && req_ready && !bus.req_we;
        wr_acc = bus.req_valid && req_ready && bus.req_we;
        push = rd_vld_q[R_LATENCY-1];
        pop = fifo_cnt_q != '0 && bus.rsp_ready;
        en_d = rd_acc || wr_acc;
        we_d = wr_acc;
        addr_d = en_d ? bus.req_addr : addr_q;
        din_d = en_d ? bus.req_data : din_q;
        rd_vld_d = (rd_vld_q << 1) | R_LATENCY'(rd_acc);
        rd_addr_d[0] = bus.req_addr;
        for (int i = 1; i < R_LATENCY; i++) rd_addr_d[i] = rd_addr_q[i-1];
        wr_pipe_d = (wr_pipe_q << 1) | W_LATENCY'(wr_acc);
        rd_out_d = rd_out_q + CNT_W'(rd_acc) - CNT_W'(push);
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d = !push ? wr_ptr_q : wr_ptr_q == PTR_W'(RSP_DEPTH - 1) ? '0 : wr_ptr_q + PTR_W'(1);
        rd_ptr_d = !pop ? rd_ptr_q : rd_ptr_q == PTR_W'(RSP_DEPTH - 1) ? '0 : rd_ptr_q + PTR_W'(1);
        fifo_data_d = fifo_data_q;
        fifo_addr_d = fifo_addr_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = bus.dout;
            fifo_addr_d[wr_ptr_q] = rd_addr_q[R_LATENCY-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            rd_vld_q   <= '0;
            wr_pipe_q  <= '0;
            rd_out_q   <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < R_LATENCY; i++) rd_addr_q[i] <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
            end
        end else begin
            en_q        <= en_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rd_vld_q    <= rd_vld_d;
            rd_addr_q   <= rd_addr_d;
            wr_pipe_q   <= wr_pipe_d;
            rd_out_q    <= rd_out_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_data_q <= fifo_data_d;
            fifo_addr_q <= fifo_addr_d;
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) push |-> fifo_cnt_q < CNT_W'(RSP_DEPTH));

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = fifo_cnt_q != '0;
    assign bus.rsp_data  = fifo_data_q[rd_ptr_q];
    assign bus.rsp_addr  = fifo_addr_q[rd_ptr_q];
    assign bus.wr_done   = wr_pipe_q[W_LATENCY-1];
    assign bus.en        = en_q;
    assign bus.we        = we_q;
    assign bus.addr      = addr_q;
    assign bus.din       = din_q;
endmodule

// File: tb/tb_mem_port_requester.sv
// tb_mem_port_requester: scoreboard bench driving mem_port_requester against a registered-read RAM model
module tb_mem_port_requester;
    localparam int DW = 8, AD = 16, AW = 4, RL = 2, WL = 1, RD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_requester_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();
    mem_port_requester #(
        .DATA_WIDTH(DW), .ADDRESS_DEPTH(AD), .R_LATENCY(RL), .W_LATENCY(WL), .RSP_DEPTH(RD)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    logic [DW-1:0] ram [AD];
    logic [DW-1:0] ram_q = '0;
    logic [DW-1:0] ref_mem [AD];
    logic [AW+DW-1:0] exp_q [$];
    logic [AW+DW-1:0] exp_e;
    int checks = 0, passed = 0;
    int rsp_n = 0, wr_done_n = 0;

    // RAM stand-in: en sampled at one edge, read data visible after that edge
    assign bus.dout = ram_q;
    always @(posedge clk) begin
        if (bus.en) begin
            if (bus.we) ram[bus.addr] = bus.din;
            else ram_q <= ram[bus.addr];
        end
    end

    // scoreboard: push expected on accepted read, pop on response handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_n++;
                checks++;
                if (exp_q.size() == 0)
                    $display("FAIL rsp_unexpected got addr=%0d data=%h want none", bus.rsp_addr, bus.rsp_data);
                else begin
                    exp_e = exp_q.pop_front();
                    if ({bus.rsp_addr, bus.rsp_data} !== exp_e)
                        $display("FAIL rsp_data got addr=%0d data=%h want addr=%0d data=%h",
                                 bus.rsp_addr, bus.rsp_data, exp_e[AW+DW-1:DW], exp_e[DW-1:0]);
                    else passed++;
                end
            end
            if (bus.wr_done) wr_done_n++;
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_we) ref_mem[bus.req_addr] = bus.req_data;
                else exp_q.push_back({bus.req_addr, ref_mem[bus.req_addr]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_data = '0; bus.rsp_ready = 1;
        rst_n = 0;
        repeat (3) tick();
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_addr, bus.wr_done, bus.en, bus.we, bus.addr, bus.din} !== '0)
            $display("FAIL rst_outputs got ready=%b rsp_valid=%b en=%b wr_done=%b want all 0",
                     bus.req_ready, bus.rsp_valid, bus.en, bus.wr_done);
        else passed++;
        rst_n = 1;
        tick();
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL idle_ready got=%b want=1", bus.req_ready); else passed++;
        checks++; if (bus.en !== 1'b0) $display("FAIL idle_en got=%b want=0", bus.en); else passed++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL idle_rsp_valid got=%b want=0", bus.rsp_valid); else passed++;
        checks++; if (bus.wr_done !== 1'b0) $display("FAIL idle_wr_done got=%b want=0", bus.wr_done); else passed++;
    endtask

    task automatic test_raw();
        bus.rsp_ready = 1;
        bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 4'd3; bus.req_data = 8'hA5;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL raw_wr_ready got=%b want=1", bus.req_ready); else passed++;
        tick();
        bus.req_we = 0; bus.req_data = '0;
        checks++;
        if ({bus.en, bus.we, bus.addr, bus.din} !== {1'b1, 1'b1, 4'd3, 8'hA5})
            $display("FAIL raw_wr_issue got en=%b we=%b addr=%0d din=%h want 1 1 3 a5", bus.en, bus.we, bus.addr, bus.din);
        else passed++;
        checks++; if (bus.wr_done !== 1'b1) $display("FAIL raw_wr_done got=%b want=1", bus.wr_done); else passed++;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) $display("FAIL raw_rd_stall got=%b want=0", bus.req_ready); else passed++;
        tick();
        checks++; if (bus.en !== 1'b0) $display("FAIL raw_stall_en got=%b want=0", bus.en); else passed++;
        checks++; if (bus.wr_done !== 1'b0) $display("FAIL raw_wr_done_pulse got=%b want=0", bus.wr_done); else passed++;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL raw_rd_ready got=%b want=1", bus.req_ready); else passed++;
        tick();
        bus.req_valid = 0;
        checks++;
        if ({bus.en, bus.we, bus.addr} !== {1'b1, 1'b0, 4'd3})
            $display("FAIL raw_rd_issue got en=%b we=%b addr=%0d want 1 0 3", bus.en, bus.we, bus.addr);
        else passed++;
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL raw_rsp_early got=%b want=0", bus.rsp_valid); else passed++;
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_addr, bus.rsp_data} !== {1'b1, 4'd3, 8'hA5})
            $display("FAIL raw_rsp got valid=%b addr=%0d data=%h want 1 3 a5", bus.rsp_valid, bus.rsp_addr, bus.rsp_data);
        else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        int k = 0;
        int n0 = rsp_n;
        bus.rsp_ready = 0;
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = 1; bus.req_we = 0; bus.req_addr = AW'(k);
            @(negedge clk);
            if (bus.req_ready) k++;
            tick();
        end
        checks++; if (k !== 4) $display("FAIL bp_accepted got=%0d want=4", k); else passed++;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) $display("FAIL bp_ready got=%b want=0", bus.req_ready); else passed++;
        tick();
        bus.rsp_ready = 1;
        for (int c = 0; c < 40 && k < 6; c++) begin
            bus.req_addr = AW'(k);
            @(negedge clk);
            if (bus.req_ready) k++;
            tick();
        end
        bus.req_valid = 0;
        checks++; if (k !== 6) $display("FAIL bp_resume got=%0d want=6", k); else passed++;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        checks++; if (rsp_n - n0 !== 6) $display("FAIL bp_rsp_count got=%0d want=6", rsp_n - n0); else passed++;
    endtask

    task automatic test_stream();
        int k = 0, stall = 0;
        int n0 = rsp_n;
        bus.rsp_ready = 1;
        for (int c = 0; c < 40 && k < 12; c++) begin
            bus.req_valid = 1; bus.req_we = 0; bus.req_addr = AW'(k + 4);
            @(negedge clk);
            if (bus.req_ready) k++; else stall++;
            tick();
        end
        bus.req_valid = 0;
        checks++; if (stall !== 0) $display("FAIL stream_stalls got=%0d want=0", stall); else passed++;
        tick();
        tick();
        @(negedge clk);
        #1;
        checks++; if (rsp_n - n0 !== 12) $display("FAIL stream_rate got=%0d want=12", rsp_n - n0); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        bus.rsp_ready = 0;
        for (int r = 0; r < 3; r++) begin
            bus.req_valid = 1; bus.req_we = (r == 2); bus.req_addr = AW'(r == 2 ? 7 : r + 1); bus.req_data = 8'h3C;
            @(negedge clk);
            tick();
        end
        bus.req_valid = 0;
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.wr_done, bus.en, bus.we} !== '0)
            $display("FAIL mid_rst_outputs got ready=%b rsp_valid=%b wr_done=%b en=%b want all 0",
                     bus.req_ready, bus.rsp_valid, bus.wr_done, bus.en);
        else passed++;
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1;
        bus.rsp_ready = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.wr_done) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL mid_rst_stale got=%0d want=0", bad); else passed++;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL mid_rst_ready got=%b want=1", bus.req_ready); else passed++;
        tick();
    endtask

    task automatic test_wrap();
        logic [DW-1:0] wd [10];
        logic acc;
        int b;
        int n0 = rsp_n;
        int w0 = wr_done_n;
        for (int a = 0; a < 10; a++) wd[a] = DW'($urandom);
        for (int p = 0; p < 20; p++) begin
            bus.req_valid = 1; bus.req_we = (p < 10); bus.req_addr = AW'(p % 10); bus.req_data = wd[p % 10];
            acc = 0;
            b = 0;
            while (!acc && b < 20) begin
                @(negedge clk);
                acc = bus.req_ready;
                b++;
                tick();
                bus.rsp_ready = 1'($urandom_range(0, 1));
            end
            if (!acc) begin
                checks++;
                $display("FAIL wrap_issue_timeout got no accept want accept p=%0d", p);
            end
        end
        bus.req_valid = 0;
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            tick();
            bus.rsp_ready = 1'($urandom_range(0, 1));
        end
        bus.rsp_ready = 1;
        repeat (2) tick();
        checks++; if (exp_q.size() !== 0) $display("FAIL wrap_drain got=%0d want=0", exp_q.size()); else passed++;
        checks++; if (rsp_n - n0 !== 10) $display("FAIL wrap_rsp_count got=%0d want=10", rsp_n - n0); else passed++;
        checks++; if (wr_done_n - w0 !== 10) $display("FAIL wrap_wr_done got=%0d want=10", wr_done_n - w0); else passed++;
    endtask

    initial begin
        for (int i = 0; i < AD; i++) begin
            ram[i] = DW'(i * 13 + 5);
            ref_mem[i] = DW'(i * 13 + 5);
        end
        test_reset();
        test_raw();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
